// File: rtl/obstacle_arb_pkg.sv
// Shared widths, port indices and the response tag carried through the read pipe.
package obstacle_arb_pkg;
  localparam int OBST_ADDR_W = 11;
  localparam int OBST_DATA_W = 32;
  localparam int OBST_BE_W   = 4;

  localparam logic PORT_R = 1'b0;
  localparam logic PORT_G = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rsp_tag_t;
endpackage

// File: rtl/obstacle_rsp_pipe.sv
// Tag delay line matching the memory read latency; tag_out lines up with mem_readdata.
// READ_LATENCY cycles, never stalls.
module obstacle_rsp_pipe
  import obstacle_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage [READ_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/obstacle_mem_arbiter.sv
// Shares the single-port obstacle memory between renderer (read) and game logic (r/w).
// Read data READ_LATENCY+1 cycles after handshake; renderer wins unless game logic has waited MAX_WAIT cycles.
module obstacle_mem_arbiter
  import obstacle_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [OBST_ADDR_W-1:0] r_addr,
  output logic                   r_rsp_valid,
  output logic [OBST_DATA_W-1:0] r_rsp_data,
  input  logic                   g_valid,
  output logic                   g_ready,
  input  logic                   g_write,
  input  logic [OBST_ADDR_W-1:0] g_addr,
  input  logic [OBST_DATA_W-1:0] g_wdata,
  input  logic [OBST_BE_W-1:0]   g_be,
  output logic                   g_rsp_valid,
  output logic [OBST_DATA_W-1:0] g_rsp_data,
  output logic [OBST_ADDR_W-1:0] mem_address,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [OBST_DATA_W-1:0] mem_writedata,
  output logic [OBST_BE_W-1:0]   mem_byteenable,
  output logic                   mem_clken,
  input  logic [OBST_DATA_W-1:0] mem_readdata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic       run;
  logic [3:0] wait_cnt;
  logic       grant_r;
  logic       grant_g;
  rsp_tag_t   tag_in;
  rsp_tag_t   tag_out;

  // run keeps every grant and strobe low while reset is asserted
  always_comb begin
    grant_r = run && r_valid && !(g_valid && (wait_cnt >= WAIT_LIMIT));
    grant_g = run && g_valid && !grant_r;
  end

  assign r_ready   = grant_r;
  assign g_ready   = grant_g;
  assign mem_clken = run;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    tag_in         = '0;
    if (grant_r) begin
      mem_chipselect = 1'b1;
      mem_address    = r_addr;
      mem_byteenable = 4'hF;
      tag_in.valid   = 1'b1;
      tag_in.port    = PORT_R;
    end else if (grant_g) begin
      mem_chipselect = 1'b1;
      mem_write      = g_write;
      mem_address    = g_addr;
      mem_writedata  = g_wdata;
      mem_byteenable = g_write ? g_be : 4'hF;
      tag_in.valid   = !g_write;
      tag_in.port    = PORT_G;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (grant_g) begin
        wait_cnt <= '0;
      end else if (g_valid && (wait_cnt < WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  obstacle_rsp_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rsp_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Read data is captured the cycle it appears at the memory port, so responses retire in issue order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      g_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      g_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= tag_out.valid && (tag_out.port == PORT_R);
      g_rsp_valid <= tag_out.valid && (tag_out.port == PORT_G);
      if (tag_out.valid && (tag_out.port == PORT_R)) r_rsp_data <= mem_readdata;
      if (tag_out.valid && (tag_out.port == PORT_G)) g_rsp_data <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_obstacle_mem_arbiter.sv
// Directed bench: instance 0 has READ_LATENCY=1, instance 1 has READ_LATENCY=2; both MAX_WAIT=4.
module tb_obstacle_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        r_valid [2];
  logic        r_ready [2];
  logic [10:0] r_addr [2];
  logic        r_rsp_valid [2];
  logic [31:0] r_rsp_data [2];
  logic        g_valid [2];
  logic        g_ready [2];
  logic        g_write [2];
  logic [10:0] g_addr [2];
  logic [31:0] g_wdata [2];
  logic [3:0]  g_be [2];
  logic        g_rsp_valid [2];
  logic [31:0] g_rsp_data [2];
  logic [10:0] mem_addr [2];
  logic        mem_cs [2];
  logic        mem_we [2];
  logic [31:0] mem_wd [2];
  logic [3:0]  mem_be [2];
  logic        mem_clken [2];
  logic [31:0] mem_rd [2];

  obstacle_mem_arbiter #(.READ_LATENCY(1), .MAX_WAIT(4)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .r_valid(r_valid[0]), .r_ready(r_ready[0]), .r_addr(r_addr[0]),
    .r_rsp_valid(r_rsp_valid[0]), .r_rsp_data(r_rsp_data[0]),
    .g_valid(g_valid[0]), .g_ready(g_ready[0]), .g_write(g_write[0]), .g_addr(g_addr[0]),
    .g_wdata(g_wdata[0]), .g_be(g_be[0]), .g_rsp_valid(g_rsp_valid[0]), .g_rsp_data(g_rsp_data[0]),
    .mem_address(mem_addr[0]), .mem_chipselect(mem_cs[0]), .mem_write(mem_we[0]),
    .mem_writedata(mem_wd[0]), .mem_byteenable(mem_be[0]), .mem_clken(mem_clken[0]),
    .mem_readdata(mem_rd[0]));

  obstacle_mem_arbiter #(.READ_LATENCY(2), .MAX_WAIT(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .r_valid(r_valid[1]), .r_ready(r_ready[1]), .r_addr(r_addr[1]),
    .r_rsp_valid(r_rsp_valid[1]), .r_rsp_data(r_rsp_data[1]),
    .g_valid(g_valid[1]), .g_ready(g_ready[1]), .g_write(g_write[1]), .g_addr(g_addr[1]),
    .g_wdata(g_wdata[1]), .g_be(g_be[1]), .g_rsp_valid(g_rsp_valid[1]), .g_rsp_data(g_rsp_data[1]),
    .mem_address(mem_addr[1]), .mem_chipselect(mem_cs[1]), .mem_write(mem_we[1]),
    .mem_writedata(mem_wd[1]), .mem_byteenable(mem_be[1]), .mem_clken(mem_clken[1]),
    .mem_readdata(mem_rd[1]));

  // Memory model: byte-enabled write at the edge, read data available READ_LATENCY cycles later
  logic [31:0] mem [2][2048];
  logic [31:0] rd_pipe [2][2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_cs[k] && mem_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[k][b]) mem[k][mem_addr[k]][b*8 +: 8] <= mem_wd[k][b*8 +: 8];
      end
      rd_pipe[k][1] <= rd_pipe[k][0];
      rd_pipe[k][0] <= mem[k][mem_addr[k]];
    end
  end
  assign mem_rd[0] = rd_pipe[0][0];
  assign mem_rd[1] = rd_pipe[1][1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      r_valid[k] = 1'b0; g_valid[k] = 1'b0; g_write[k] = 1'b0;
      r_addr[k] = '0; g_addr[k] = '0; g_wdata[k] = '0; g_be[k] = '0;
    end
  endtask

  // Response monitor for the interleaved run on instance 1
  logic [31:0] r_q[$];
  logic [31:0] g_q[$];
  bit mon_en = 1'b0;
  int r_cnt = 0;
  int g_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (r_rsp_valid[1]) begin
        r_cnt++;
        if (r_q.size() == 0) chk("E r extra rsp", 32'd1, 32'd0);
        else chk("E r data", r_rsp_data[1], r_q.pop_front());
      end
      if (g_rsp_valid[1]) begin
        g_cnt++;
        if (g_q.size() == 0) chk("E g extra rsp", 32'd1, 32'd0);
        else chk("E g data", g_rsp_data[1], g_q.pop_front());
      end
    end
  end

  typedef struct {
    logic rv; logic [10:0] ra;
    logic gv; logic gw; logic [10:0] ga; logic [31:0] gd; logic [3:0] gbe;
    logic e_rr; logic e_gr; logic e_cs; logic e_w;
    logic [10:0] e_addr; logic [31:0] e_wd; logic [3:0] e_be;
  } vec_t;

  vec_t vt [10];

  initial begin
    // Arbitration/drive table for instance 0; wait_cnt starts at 0 and climbs while game logic is held off
    vt[0] = '{1'b1, 11'h011, 1'b1, 1'b1, 11'h100, 32'hAAAA5555, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 11'h011, 32'h0, 4'hF};
    vt[1] = vt[0];
    vt[2] = vt[0];
    vt[3] = vt[0];
    vt[4] = '{1'b1, 11'h011, 1'b1, 1'b1, 11'h100, 32'hAAAA5555, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 11'h100, 32'hAAAA5555, 4'hA};
    vt[5] = '{1'b1, 11'h012, 1'b1, 1'b0, 11'h101, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h012, 32'h0, 4'hF};
    vt[6] = '{1'b0, 11'h012, 1'b1, 1'b0, 11'h101, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 11'h101, 32'h0, 4'hF};
    vt[7] = '{1'b0, 11'h012, 1'b0, 1'b1, 11'h101, 32'h55, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 32'h0, 4'h0};
    vt[8] = '{1'b0, 11'h000, 1'b1, 1'b1, 11'h3FF, 32'h11223344, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 11'h3FF, 32'h11223344, 4'h5};
    vt[9] = '{1'b1, 11'h7FE, 1'b0, 1'b1, 11'h3FF, 32'h11223344, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 11'h7FE, 32'h0, 4'hF};

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 2048; a++) mem[k][a] = '0;
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    r_valid[0] = 1'b1;
    g_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset r_ready", r_ready[k], 0);
      chk("reset g_ready", g_ready[k], 0);
      chk("reset mem_cs", mem_cs[k], 0);
      chk("reset mem_clken", mem_clken[k], 0);
      chk("reset rsp_valid", {r_rsp_valid[k], g_rsp_valid[k]}, 0);
      chk("reset rsp_data", r_rsp_data[k] | g_rsp_data[k], 0);
      chk("reset mem_addr/be/wd", {mem_addr[k], mem_be[k], mem_we[k]} | mem_wd[k], 0);
    end
    idle();
    step(); step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    chk("clken out of reset", mem_clken[0], 1);

    for (int i = 0; i < 10; i++) begin
      step();
      r_valid[0] = vt[i].rv; r_addr[0] = vt[i].ra;
      g_valid[0] = vt[i].gv; g_write[0] = vt[i].gw; g_addr[0] = vt[i].ga;
      g_wdata[0] = vt[i].gd; g_be[0] = vt[i].gbe;
      @(negedge clk);
      chk($sformatf("T%0d r_ready", i), r_ready[0], vt[i].e_rr);
      chk($sformatf("T%0d g_ready", i), g_ready[0], vt[i].e_gr);
      chk($sformatf("T%0d mem_cs", i), mem_cs[0], vt[i].e_cs);
      chk($sformatf("T%0d mem_write", i), mem_we[0], vt[i].e_w);
      chk($sformatf("T%0d mem_addr", i), mem_addr[0], vt[i].e_addr);
      chk($sformatf("T%0d mem_wd", i), mem_wd[0], vt[i].e_wd);
      chk($sformatf("T%0d mem_be", i), mem_be[0], vt[i].e_be);
    end
    step(); idle();
    repeat (4) step();

    // Single renderer read, latency 1
    mem[0][11'h010] = 32'hDEADBEEF;
    r_valid[0] = 1'b1; r_addr[0] = 11'h010;
    @(negedge clk); chk("A r_ready", r_ready[0], 1);
    step(); r_valid[0] = 1'b0;
    @(negedge clk); chk("A rsp not early", r_rsp_valid[0], 0);
    step();
    @(negedge clk);
    chk("A rsp valid", r_rsp_valid[0], 1);
    chk("A rsp data", r_rsp_data[0], 32'hDEADBEEF);
    chk("A g quiet", g_rsp_valid[0], 0);
    step();
    @(negedge clk);
    chk("A rsp one pulse", r_rsp_valid[0], 0);
    chk("A data held", r_rsp_data[0], 32'hDEADBEEF);

    // Partial game write then read-back
    mem[0][11'h7FF] = 32'hCAFEBABE;
    step();
    g_valid[0] = 1'b1; g_write[0] = 1'b1; g_addr[0] = 11'h7FF; g_wdata[0] = 32'h12345678; g_be[0] = 4'b0011;
    @(negedge clk); chk("B write ready", g_ready[0], 1);
    step(); g_write[0] = 1'b0;
    @(negedge clk); chk("B read ready", g_ready[0], 1);
    step(); g_valid[0] = 1'b0;
    @(negedge clk); chk("B no rsp for write", g_rsp_valid[0], 0);
    step();
    @(negedge clk);
    chk("B rsp valid", g_rsp_valid[0], 1);
    chk("B merged data", g_rsp_data[0], 32'hCAFE5678);
    chk("B memory bytes", mem[0][11'h7FF], 32'hCAFE5678);
    chk("B r quiet", r_rsp_valid[0], 0);

    // Game write then renderer read of the same word next cycle
    step(); idle();
    g_valid[0] = 1'b1; g_write[0] = 1'b1; g_addr[0] = 11'h055; g_wdata[0] = 32'h0BADF00D; g_be[0] = 4'hF;
    @(negedge clk); chk("C write ready", g_ready[0], 1);
    step(); idle();
    r_valid[0] = 1'b1; r_addr[0] = 11'h055;
    @(negedge clk); chk("C read ready", r_ready[0], 1);
    step(); idle();
    @(negedge clk); chk("C no g rsp", g_rsp_valid[0], 0);
    step();
    @(negedge clk);
    chk("C r rsp valid", r_rsp_valid[0], 1);
    chk("C r rsp data", r_rsp_data[0], 32'h0BADF00D);
    chk("C g still quiet", g_rsp_valid[0], 0);

    // Both valid continuously: R,R,R,R,G repeating
    step();
    r_valid[0] = 1'b1; r_addr[0] = 11'h020;
    g_valid[0] = 1'b1; g_addr[0] = 11'h021;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("D%0d r_ready", i), r_ready[0], (i % 5) != 4);
      chk($sformatf("D%0d g_ready", i), g_ready[0], (i % 5) == 4);
      step();
    end
    idle();
    repeat (4) step();

    // Interleaved reads on instance 1, latency 2
    for (int i = 0; i < 10; i++) begin
      mem[1][11'h100 + 11'(i)] = 32'hA0000000 | i;
      mem[1][11'h300 + 11'(i)] = 32'hB0000000 | i;
    end
    mon_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) begin
        r_valid[1] = 1'b1; g_valid[1] = 1'b0; r_addr[1] = 11'h100 + 11'(c / 2);
        r_q.push_back(32'hA0000000 | (c / 2));
      end else begin
        r_valid[1] = 1'b0; g_valid[1] = 1'b1; g_addr[1] = 11'h300 + 11'(c / 2);
        g_q.push_back(32'hB0000000 | (c / 2));
      end
      @(negedge clk);
      chk($sformatf("E%0d ready", c), (c % 2 == 0) ? r_ready[1] : g_ready[1], 1);
      step();
    end
    idle();
    repeat (6) step();
    mon_en = 1'b0;
    chk("E r count", r_cnt, 10);
    chk("E g count", g_cnt, 10);

    // Reset with two reads in flight on instance 1
    r_valid[1] = 1'b1; r_addr[1] = 11'h100;
    @(negedge clk); chk("F r ready", r_ready[1], 1);
    step(); r_valid[1] = 1'b0; g_valid[1] = 1'b1; g_addr[1] = 11'h300;
    @(negedge clk); chk("F g ready", g_ready[1], 1);
    step(); g_valid[1] = 1'b0; r_valid[1] = 1'b1; r_addr[1] = 11'h101;
    reset_n = 1'b0;
    #1;
    chk("F rsp_valid zero", {r_rsp_valid[1], g_rsp_valid[1]}, 0);
    chk("F r_rsp_data zero", r_rsp_data[1], 0);
    chk("F g_rsp_data zero", g_rsp_data[1], 0);
    chk("F r_ready zero", r_ready[1], 0);
    chk("F mem_cs zero", mem_cs[1], 0);
    chk("F mem_addr zero", mem_addr[1], 0);
    chk("F clken zero", mem_clken[1], 0);
    r_valid[1] = 1'b0;
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("F%0d no stale rsp", i), {r_rsp_valid[1], g_rsp_valid[1]}, 0);
      step();
    end
    r_valid[1] = 1'b1; r_addr[1] = 11'h102;
    @(negedge clk); chk("F new ready", r_ready[1], 1);
    step(); r_valid[1] = 1'b0;
    @(negedge clk); chk("F new rsp N+1", r_rsp_valid[1], 0);
    step();
    @(negedge clk); chk("F new rsp N+2", r_rsp_valid[1], 0);
    step();
    @(negedge clk);
    chk("F new rsp valid", r_rsp_valid[1], 1);
    chk("F new rsp data", r_rsp_data[1], 32'hA0000002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
